// File: rtl/mesh_terminal_rx.sv
// Mesh network terminal receiver: pops packets from a router output port, keeps
// those addressed to this node (or broadcast) in a small FIFO, and counts drops.
module mesh_terminal_rx #(
    parameter int          PAKG_SIZE  = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [3:0]  ROW_ID     = 4'd0,
    parameter logic [3:0]  COL_ID     = 4'd0,
    parameter logic [7:0]  BDCST      = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pndng,
    input  logic [PAKG_SIZE-1:0] data_out,
    output logic                 pop,
    output logic                 rx_valid,
    output logic [PAKG_SIZE-1:0] rx_data,
    output logic                 rx_bcst,
    input  logic                 rx_ready,
    output logic                 err_addr,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          err_addr_q, err_addr_d;

    logic [PAKG_SIZE-1:0] mem_q  [FIFO_DEPTH];
    logic                 bcst_q [FIFO_DEPTH];

    logic is_bcst, is_local, accept, in_pop, wr_en, rd_en, full;

    // Header decode of the packet the router is currently presenting
    always_comb begin
        is_bcst  = (data_out[31:24] == BDCST);
        is_local = (data_out[23:20] == ROW_ID) && (data_out[19:16] == COL_ID);
        accept   = is_bcst || is_local;
        in_pop   = (state_q == POP);
        wr_en    = in_pop && accept;
        full     = (count_q == FULL_CNT);
        rd_en    = rx_valid && rx_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fullness is checked before popping so nothing is lost
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pndng && !full) state_d = POP;
            POP:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pop = (state_q == POP);
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pkt_cnt_d  = (wr_en && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
        drop_cnt_d = (in_pop && !accept && drop_cnt_q != 16'hFFFF) ?
                     drop_cnt_q + 16'd1 : drop_cnt_q;
        err_addr_d = in_pop && !accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_addr_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Storage array has no reset; emptiness is carried entirely by count_q
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q]  <= data_out;
            bcst_q[wr_ptr_q] <= is_bcst;
        end
    end

    assign rx_valid = (count_q != '0);
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign rx_bcst  = rx_valid ? bcst_q[rd_ptr_q] : 1'b0;
    assign err_addr = err_addr_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mesh_terminal_rx.sv
// Scoreboard bench for mesh_terminal_rx at ROW_ID=2, COL_ID=3: a router model
// feeds directed packets, a monitor checks every delivered packet in order.
module tb_mesh_terminal_rx;

    logic        clk;
    logic        reset;
    logic        pndng;
    logic [31:0] data_out;
    logic        pop;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_bcst;
    logic        rx_ready;
    logic        err_addr;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    mesh_terminal_rx #(
        .PAKG_SIZE (32),
        .FIFO_DEPTH(4),
        .ROW_ID    (4'd2),
        .COL_ID    (4'd3),
        .BDCST     (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng),
        .data_out(data_out),
        .pop     (pop),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_bcst (rx_bcst),
        .rx_ready(rx_ready),
        .err_addr(err_addr),
        .pkt_cnt (pkt_cnt),
        .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic        b;
    } exp_t;

    logic [31:0] rq[$];
    exp_t        sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    int err_seen = 0;
    int cyc      = 0;
    int last_pop = -1;
    bit stream_mode = 0;
    bit prev_valid  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // acc/bc are the hand-decoded expectations for this packet
    task automatic send(input logic [31:0] pkt, input bit acc, input bit bc);
        exp_t e;
        rq.push_back(pkt);
        if (acc) begin
            e.d = pkt;
            e.b = bc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_one();
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Router output-port model: head is consumed on the edge that ends a pop cycle
    initial begin
        bit consume;
        pndng    = 1'b0;
        data_out = '0;
        forever begin
            @(negedge clk);
            consume = pop;
            @(posedge clk);
            #1;
            if (consume && rq.size() > 0) void'(rq.pop_front());
            pndng    = (rq.size() != 0);
            data_out = pndng ? rq[0] : 32'h0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (pop) begin
                pop_cnt++;
                if (stream_mode && last_pop >= 0) chk("pop_period", cyc - last_pop, 3);
                last_pop = cyc;
            end
            if (err_addr) err_seen++;
            if (stream_mode && rx_valid) chk("stream_occupancy", {31'b0, prev_valid}, 0);
            prev_valid = rx_valid;
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rx_valid", {31'b0, rx_valid}, 0);
                end else begin
                    e = sb.pop_front();
                    $display("rx pkt %h bcst %b (expected %h bcst %b)", rx_data, rx_bcst, e.d, e.b);
                    chk("rx_data", rx_data, e.d);
                    chk("rx_bcst", {31'b0, rx_bcst}, {31'b0, e.b});
                end
            end
        end
    end

    initial begin
        bit found;
        reset    = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_pop", {31'b0, pop}, 0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 0);
        chk("rst_rx_bcst", {31'b0, rx_bcst}, 0);
        chk("rst_err_addr", {31'b0, err_addr}, 0);
        chk("rst_pkt_cnt", {16'b0, pkt_cnt}, 0);
        chk("rst_drop_cnt", {16'b0, drop_cnt}, 0);
        chk("rst_rx_data", rx_data, 0);

        // Addressed packet and latency
        send(32'h0123_8ABC, 1, 0);
        @(negedge clk);
        chk("lat_pop_before", {31'b0, pop}, 0);
        @(negedge clk);
        chk("lat_pop", {31'b0, pop}, 1);
        chk("lat_valid_early", {31'b0, rx_valid}, 0);
        @(negedge clk);
        chk("lat_pop_single", {31'b0, pop}, 0);
        chk("lat_rx_valid", {31'b0, rx_valid}, 1);
        chk("lat_rx_bcst", {31'b0, rx_bcst}, 0);
        chk("lat_pkt_cnt", {16'b0, pkt_cnt}, 1);
        drain_one();

        // Misrouted packet
        @(negedge clk);
        send(32'h0114_0001, 0, 0);
        wait_cycles(8);
        chk("mis_err_pulses", err_seen, 1);
        chk("mis_drop_cnt", {16'b0, drop_cnt}, 1);
        chk("mis_rx_valid", {31'b0, rx_valid}, 0);
        chk("mis_pkt_cnt", {16'b0, pkt_cnt}, 1);

        // Broadcast packet
        send(32'hFF00_0005, 1, 1);
        wait_cycles(5);
        chk("bc_rx_valid", {31'b0, rx_valid}, 1);
        chk("bc_rx_bcst", {31'b0, rx_bcst}, 1);
        chk("bc_rx_data", rx_data, 32'hFF00_0005);
        chk("bc_pkt_cnt", {16'b0, pkt_cnt}, 2);
        drain_one();

        // Backpressure: six packets, four-entry buffer
        @(posedge clk); #1 pop_cnt = 0;
        @(negedge clk);
        send(32'h0123_0000, 1, 0);
        send(32'h0123_0001, 1, 0);
        send(32'h0123_0002, 1, 0);
        send(32'h0123_0003, 1, 0);
        send(32'h0123_0004, 1, 0);
        send(32'h0123_0005, 1, 0);
        wait_cycles(10);
        chk("bp_head_early", rx_data, 32'h0123_0000);
        wait_cycles(20);
        chk("bp_pop_cnt_full", pop_cnt, 4);
        chk("bp_pop_idle", {31'b0, pop}, 0);
        chk("bp_head_stable", rx_data, 32'h0123_0000);
        chk("bp_pkt_cnt", {16'b0, pkt_cnt}, 6);
        drain_one();
        wait_cycles(10);
        chk("bp_pop_resume", pop_cnt, 5);
        chk("bp_new_head", rx_data, 32'h0123_0001);
        @(posedge clk); #1 rx_ready = 1'b1;
        wait_cycles(30);
        chk("bp_pop_total", pop_cnt, 6);
        chk("bp_drained", {31'b0, rx_valid}, 0);
        chk("bp_pkt_cnt_end", {16'b0, pkt_cnt}, 8);
        chk("bp_sb_empty", sb.size(), 0);

        // Streaming from a fresh reset
        do_reset();
        @(posedge clk); #1;
        rx_ready    = 1'b1;
        pop_cnt     = 0;
        last_pop    = -1;
        stream_mode = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) send(32'h0123_1000 + i, 1, 0);
        wait_cycles(40);
        chk("st_pop_cnt", pop_cnt, 10);
        chk("st_pkt_cnt", {16'b0, pkt_cnt}, 10);
        chk("st_rx_valid", {31'b0, rx_valid}, 0);
        chk("st_sb_empty", sb.size(), 0);
        @(posedge clk); #1 stream_mode = 1'b0;

        // Reset landing on the pop cycle
        @(negedge clk);
        send(32'h0123_2222, 1, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (pop) found = 1;
        end
        chk("rp_pop_seen", {31'b0, found}, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("rp_pop", {31'b0, pop}, 0);
        chk("rp_rx_valid", {31'b0, rx_valid}, 0);
        chk("rp_pkt_cnt", {16'b0, pkt_cnt}, 0);
        chk("rp_drop_cnt", {16'b0, drop_cnt}, 0);
        wait_cycles(6);
        chk("rp_no_late_write", {31'b0, rx_valid}, 0);
        chk("rp_pkt_cnt_late", {16'b0, pkt_cnt}, 0);

        chk("final_err_pulses", err_seen, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
